// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing logic: requester ids, default widths
// and the layout of the static {write_enable, dest_reg} field.
package alu_pkg;

    localparam int DEF_OPERAND_SIZE     = 32;
    localparam int DEF_REG_ADDRESS_SIZE = 5;
    localparam int DEF_OP_SIZE          = 1;
    localparam int DEF_CNT_W            = 16;

    localparam int STATIC_W = DEF_REG_ADDRESS_SIZE + 1;
    localparam int WE_BIT   = DEF_REG_ADDRESS_SIZE;

    typedef enum logic {
        REQ_EXEC = 1'b0,
        REQ_AGU  = 1'b1
    } req_id_e;

    function automatic int static_width(input int reg_address_size);
        return reg_address_size + 1;
    endfunction

    // Maps a one-hot grant back to the requester that owns it.
    function automatic req_id_e grant_index(input logic [1:0] grant);
        return grant[1] ? REQ_AGU : REQ_EXEC;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request, ALU-side and response signals of the shared-ALU arbiter.
// The slave modport is the arbiter, the master modport is its environment.
interface alu_share_arbiter_if
    import alu_pkg::*;
#(
    parameter int OPERAND_SIZE     = DEF_OPERAND_SIZE,
    parameter int REG_ADDRESS_SIZE = DEF_REG_ADDRESS_SIZE,
    parameter int OP_SIZE          = DEF_OP_SIZE,
    parameter int CNT_W            = DEF_CNT_W
);

    logic                        flush;

    logic                        r0_valid;
    logic                        r0_ready;
    logic [OP_SIZE-1:0]          r0_op;
    logic [OPERAND_SIZE-1:0]     r0_operand1;
    logic [OPERAND_SIZE-1:0]     r0_operand2;
    logic [REG_ADDRESS_SIZE:0]   r0_static;

    logic                        r1_valid;
    logic                        r1_ready;
    logic [OP_SIZE-1:0]          r1_op;
    logic [OPERAND_SIZE-1:0]     r1_operand1;
    logic [OPERAND_SIZE-1:0]     r1_operand2;
    logic [REG_ADDRESS_SIZE:0]   r1_static;

    logic [OP_SIZE-1:0]          alu_op;
    logic [OPERAND_SIZE-1:0]     alu_operand1;
    logic [OPERAND_SIZE-1:0]     alu_operand2;
    logic [REG_ADDRESS_SIZE:0]   alu_static_in;
    logic [OPERAND_SIZE-1:0]     alu_result;
    logic [REG_ADDRESS_SIZE:0]   alu_static_out;

    logic                        resp_valid;
    logic                        resp_ready;
    logic [OPERAND_SIZE-1:0]     resp_result;
    logic [REG_ADDRESS_SIZE:0]   resp_static;
    logic                        resp_id;

    logic [CNT_W-1:0]            conflict_count;

    modport slave (
        input  flush,
        input  r0_valid, r0_op, r0_operand1, r0_operand2, r0_static,
        output r0_ready,
        input  r1_valid, r1_op, r1_operand1, r1_operand2, r1_static,
        output r1_ready,
        output alu_op, alu_operand1, alu_operand2, alu_static_in,
        input  alu_result, alu_static_out,
        output resp_valid, resp_result, resp_static, resp_id,
        input  resp_ready,
        output conflict_count
    );

    modport master (
        output flush,
        output r0_valid, r0_op, r0_operand1, r0_operand2, r0_static,
        input  r0_ready,
        output r1_valid, r1_op, r1_operand1, r1_operand2, r1_static,
        input  r1_ready,
        input  alu_op, alu_operand1, alu_operand2, alu_static_in,
        output alu_result, alu_static_out,
        input  resp_valid, resp_result, resp_static, resp_id,
        output resp_ready,
        input  conflict_count
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on a conflict the requester that did not win
// last time is granted. Grant is one-hot (or zero) and purely combinational.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute stage (r0) and the
// address/branch unit (r1), registering each result with its requester tag.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int OPERAND_SIZE     = DEF_OPERAND_SIZE,
    parameter int REG_ADDRESS_SIZE = DEF_REG_ADDRESS_SIZE,
    parameter int OP_SIZE          = DEF_OP_SIZE,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);

    localparam int               SW       = static_width(REG_ADDRESS_SIZE);
    localparam int               WE       = REG_ADDRESS_SIZE;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic                    resp_valid_q;
    logic [OPERAND_SIZE-1:0] resp_result_q;
    logic [SW-1:0]           resp_static_q;
    req_id_e                 resp_id_q;
    req_id_e                 last_grant_q;
    logic [CNT_W-1:0]        conflict_q;

    logic                    can_accept;
    logic [1:0]              grant;
    logic                    any_grant;
    logic                    both_valid;

    // A held result blocks new grants unless it drains this same cycle.
    assign can_accept = !bus.flush && (!resp_valid_q || bus.resp_ready);
    assign any_grant  = |grant;
    assign both_valid = bus.r0_valid && bus.r1_valid;

    rr_arb2 u_arb (
        .valid      ({bus.r1_valid, bus.r0_valid}),
        .last_grant (last_grant_q),
        .enable     (can_accept),
        .grant      (grant)
    );

    assign bus.r0_ready = grant[0];
    assign bus.r1_ready = grant[1];

    // Idle cycles still present r0's operands but must never look like a write.
    always_comb begin
        bus.alu_op        = bus.r0_op;
        bus.alu_operand1  = bus.r0_operand1;
        bus.alu_operand2  = bus.r0_operand2;
        bus.alu_static_in = bus.r0_static;
        if (grant[1]) begin
            bus.alu_op        = bus.r1_op;
            bus.alu_operand1  = bus.r1_operand1;
            bus.alu_operand2  = bus.r1_operand2;
            bus.alu_static_in = bus.r1_static;
        end else if (!grant[0]) begin
            bus.alu_static_in[WE] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_static_q <= '0;
            resp_id_q     <= REQ_EXEC;
            last_grant_q  <= REQ_AGU;
        end else if (any_grant) begin
            resp_valid_q  <= 1'b1;
            resp_result_q <= bus.alu_result;
            resp_static_q <= bus.alu_static_out;
            resp_id_q     <= grant_index(grant);
            last_grant_q  <= grant_index(grant);
        end else if (bus.flush || bus.resp_ready) begin
            resp_valid_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= '0;
        end else if (both_valid && conflict_q != CNT_MAX) begin
            conflict_q <= conflict_q + CNT_ONE;
        end
    end

    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_result    = resp_result_q;
    assign bus.resp_static    = resp_static_q;
    assign bus.resp_id        = resp_id_q;
    assign bus.conflict_count = conflict_q;

    a_single_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.r0_ready && bus.r1_ready));

    a_backpressure_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (resp_valid_q && !bus.resp_ready && !bus.flush)
        |=> (resp_valid_q && $stable(resp_result_q) && $stable(resp_static_q)));

    a_flush_drops: assert property (@(posedge clk) disable iff (!rst_n)
        bus.flush |=> !resp_valid_q);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural reference model
// checked every cycle plus hand-computed expectations at key points.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.CNT_W(16)) bus  ();
    alu_share_arbiter_if #(.CNT_W(4))  bus4 ();

    alu_share_arbiter #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    alu_share_arbiter #(.CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    // op 0 adds, op 1 subtracts; the static field passes straight through.
    function automatic logic [31:0] alu_fn(input logic op, input logic [31:0] a, input logic [31:0] b);
        return op ? (a - b) : (a + b);
    endfunction

    assign bus.alu_result      = alu_fn(bus.alu_op, bus.alu_operand1, bus.alu_operand2);
    assign bus.alu_static_out  = bus.alu_static_in;
    assign bus4.alu_result     = alu_fn(bus4.alu_op, bus4.alu_operand1, bus4.alu_operand2);
    assign bus4.alu_static_out = bus4.alu_static_in;

    assign bus4.flush       = bus.flush;
    assign bus4.resp_ready  = bus.resp_ready;
    assign bus4.r0_valid    = bus.r0_valid;
    assign bus4.r0_op       = bus.r0_op;
    assign bus4.r0_operand1 = bus.r0_operand1;
    assign bus4.r0_operand2 = bus.r0_operand2;
    assign bus4.r0_static   = bus.r0_static;
    assign bus4.r1_valid    = bus.r1_valid;
    assign bus4.r1_op       = bus.r1_op;
    assign bus4.r1_operand1 = bus.r1_operand1;
    assign bus4.r1_operand2 = bus.r1_operand2;
    assign bus4.r1_static   = bus.r1_static;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Reference model: who was served last, what the output slot holds, how many conflicts seen.
    int          m_last = 1;
    bit          m_rv   = 0;
    logic [31:0] m_res  = '0;
    logic [5:0]  m_st   = '0;
    int          m_id   = 0;
    int          m_cnt  = 0;
    int          m_cnt4 = 0;

    function automatic int winner();
        if (bus.flush) return -1;
        if (m_rv && !bus.resp_ready) return -1;
        if (bus.r0_valid && bus.r1_valid) return 1 - m_last;
        if (bus.r0_valid) return 0;
        if (bus.r1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_last = 1; m_rv = 0; m_res = '0; m_st = '0; m_id = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            w = winner();
            if (w == 0) begin
                m_res = alu_fn(bus.r0_op, bus.r0_operand1, bus.r0_operand2);
                m_st  = bus.r0_static;
            end else if (w == 1) begin
                m_res = alu_fn(bus.r1_op, bus.r1_operand1, bus.r1_operand2);
                m_st  = bus.r1_static;
            end
            if (w >= 0) begin
                m_rv = 1; m_id = w; m_last = w;
            end else if (bus.flush || bus.resp_ready) begin
                m_rv = 0;
            end
            if (bus.r0_valid && bus.r1_valid) begin
                m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
                m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : m_cnt4;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        logic        e_op;
        logic [31:0] e_a, e_b;
        logic [5:0]  e_st;
        if (rst_n) begin
            w    = winner();
            e_op = (w == 1) ? bus.r1_op       : bus.r0_op;
            e_a  = (w == 1) ? bus.r1_operand1 : bus.r0_operand1;
            e_b  = (w == 1) ? bus.r1_operand2 : bus.r0_operand2;
            e_st = (w == 1) ? bus.r1_static   : bus.r0_static;
            if (w < 0) e_st[5] = 1'b0;
            checkOutput("m_r0_ready",    64'(bus.r0_ready),       64'(w == 0));
            checkOutput("m_r1_ready",    64'(bus.r1_ready),       64'(w == 1));
            checkOutput("m_alu_op",      64'(bus.alu_op),         64'(e_op));
            checkOutput("m_alu_opnd1",   64'(bus.alu_operand1),   64'(e_a));
            checkOutput("m_alu_opnd2",   64'(bus.alu_operand2),   64'(e_b));
            checkOutput("m_alu_static",  64'(bus.alu_static_in),  64'(e_st));
            checkOutput("m_resp_valid",  64'(bus.resp_valid),     64'(m_rv));
            checkOutput("m_resp_result", 64'(bus.resp_result),    64'(m_res));
            checkOutput("m_resp_static", 64'(bus.resp_static),    64'(m_st));
            checkOutput("m_resp_id",     64'(bus.resp_id),        64'(m_id));
            checkOutput("m_conflicts",   64'(bus.conflict_count), 64'(m_cnt));
            checkOutput("m_conflicts4",  64'(bus4.conflict_count), 64'(m_cnt4));
        end
    end

    task automatic applyStimulus(
        input logic v0, input logic op0, input logic [31:0] a0, input logic [31:0] b0, input logic [5:0] s0,
        input logic v1, input logic op1, input logic [31:0] a1, input logic [31:0] b1, input logic [5:0] s1,
        input logic rr, input logic fl);
        bus.r0_valid = v0; bus.r0_op = op0; bus.r0_operand1 = a0; bus.r0_operand2 = b0; bus.r0_static = s0;
        bus.r1_valid = v1; bus.r1_op = op1; bus.r1_operand1 = a1; bus.r1_operand2 = b1; bus.r1_static = s1;
        bus.resp_ready = rr;
        bus.flush      = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0,0,0,0,6'h00, 0,0,0,0,6'h00, 1,0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_resp_valid", 64'(bus.resp_valid),     64'd0);
        checkOutput("reset_conflicts",  64'(bus.conflict_count), 64'd0);
        rst_n = 1'b1;

        // Single requester r0: add 5+7
        applyStimulus(1,0,32'd5,32'd7,6'b1_00011, 0,0,0,0,6'h00, 1,0);
        checkOutput("single_r0_ready", 64'(bus.r0_ready), 64'd1);
        tick();
        checkOutput("single_valid",  64'(bus.resp_valid),  64'd1);
        checkOutput("single_result", 64'(bus.resp_result), 64'd12);
        checkOutput("single_static", 64'(bus.resp_static), 64'(6'b1_00011));
        checkOutput("single_id",     64'(bus.resp_id),     64'd0);

        // Single requester r1, back to back with the drain: 100-30
        applyStimulus(0,0,0,0,6'h00, 1,1,32'd100,32'd30,6'h05, 1,0);
        checkOutput("b2b_r1_ready", 64'(bus.r1_ready), 64'd1);
        tick();
        checkOutput("r1_result", 64'(bus.resp_result), 64'd70);
        checkOutput("r1_id",     64'(bus.resp_id),     64'd1);

        // Conflict alternation: r0 gives 3, r1 gives 70
        applyStimulus(1,0,32'd1,32'd2,6'h21, 1,1,32'd100,32'd30,6'h05, 1,0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("alt_id",     64'(bus.resp_id),     64'(i % 2));
            checkOutput("alt_result", 64'(bus.resp_result), (i % 2) ? 64'd70 : 64'd3);
        end
        checkOutput("alt_conflicts", 64'(bus.conflict_count), 64'd4);

        // Backpressure: capture 40+2, then hold with r1 pending
        applyStimulus(1,0,32'd40,32'd2,6'h11, 0,0,0,0,6'h00, 1,0);
        tick();
        checkOutput("bp_result", 64'(bus.resp_result), 64'd42);
        applyStimulus(0,0,0,0,6'h00, 1,0,32'd8,32'd9,6'h2a, 0,0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_r1_blocked", 64'(bus.r1_ready),    64'd0);
            checkOutput("bp_held",       64'(bus.resp_result), 64'd42);
            checkOutput("bp_held_valid", 64'(bus.resp_valid),  64'd1);
            tick();
        end
        applyStimulus(0,0,0,0,6'h00, 1,0,32'd8,32'd9,6'h2a, 1,0);
        checkOutput("bp_release_ready", 64'(bus.r1_ready), 64'd1);
        tick();
        checkOutput("bp_r1_result", 64'(bus.resp_result), 64'd17);
        checkOutput("bp_r1_id",     64'(bus.resp_id),     64'd1);

        // Flush wins over resp_ready and blocks the grant
        applyStimulus(1,0,32'd3,32'd4,6'h01, 0,0,0,0,6'h00, 1,1);
        checkOutput("flush_r0_ready", 64'(bus.r0_ready), 64'd0);
        tick();
        checkOutput("flush_valid", 64'(bus.resp_valid), 64'd0);
        applyStimulus(1,0,32'd3,32'd4,6'h01, 0,0,0,0,6'h00, 1,0);
        checkOutput("post_flush_r0_ready", 64'(bus.r0_ready), 64'd1);
        tick();
        checkOutput("post_flush_result", 64'(bus.resp_result), 64'd7);
        checkOutput("post_flush_valid",  64'(bus.resp_valid),  64'd1);

        // Async reset between edges while a result is held
        applyStimulus(0,0,0,0,6'h00, 0,0,0,0,6'h00, 0,0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid",     64'(bus.resp_valid),     64'd0);
        checkOutput("async_result",    64'(bus.resp_result),    64'd0);
        checkOutput("async_conflicts", 64'(bus.conflict_count), 64'd0);
        #3;
        rst_n = 1'b1;
        tick();
        applyStimulus(1,0,32'd1,32'd2,6'h21, 1,1,32'd100,32'd30,6'h05, 1,0);
        checkOutput("post_reset_r0_first", 64'(bus.r0_ready), 64'd1);
        checkOutput("post_reset_r1_wait",  64'(bus.r1_ready), 64'd0);
        tick();
        checkOutput("post_reset_id", 64'(bus.resp_id), 64'd0);

        // Saturation of the narrow counter
        repeat (20) tick();
        checkOutput("sat_conflicts16", 64'(bus.conflict_count),  64'd21);
        checkOutput("sat_conflicts4",  64'(bus4.conflict_count), 64'd15);

        applyStimulus(0,0,0,0,6'h00, 0,0,0,0,6'h00, 1,0);
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
